// File: rtl/cv32e40p_core_v_xif_pkg.sv
// CORE-V-XIF shared types and constants used by the coprocessor-side
// interface logic of the core.
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH     = 4;
  localparam int unsigned X_RFW_WIDTH    = 32;
  localparam int unsigned MAX_NUM_COPROC = 8;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   float;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/cv32e40p_xif_rr_arb.sv
// Round-robin requester pick with a registered rotate pointer; the pointer
// moves past the winner only when a grant is actually issued.
module cv32e40p_xif_rr_arb #(
  parameter int unsigned NUM_COPROC = 2,
  parameter int unsigned IDX_W      = $clog2(NUM_COPROC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_COPROC-1:0] req_i,
  input  logic                  en_i,
  output logic [NUM_COPROC-1:0] gnt_o,
  output logic [IDX_W-1:0]      gnt_idx_o,
  output logic                  any_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COPROC - 1);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             fire;

  // Scan starting at the pointer; first requester seen wins.
  always_comb begin
    win_idx = rr_ptr_q;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_COPROC; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_COPROC);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign any_o     = |req_i;
  assign fire      = en_i & any_o;
  assign gnt_idx_o = win_idx;

  always_comb begin
    gnt_o = '0;
    if (fire) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/cv32e40p_xif_result_arbiter.sv
// Shares the single XIF result channel among NUM_COPROC coprocessors through
// a round-robin pick into a one-entry output register.
module cv32e40p_xif_result_arbiter
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned NUM_COPROC = 2,
  parameter int unsigned IDX_W      = $clog2(NUM_COPROC)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic      [NUM_COPROC-1:0]       cpr_result_valid_i,
  output logic      [NUM_COPROC-1:0]       cpr_result_ready_o,
  input  x_result_t [NUM_COPROC-1:0]       cpr_result_i,
  output logic                             x_result_valid_o,
  input  logic                             x_result_ready_i,
  output x_result_t                        x_result_o,
  output logic      [IDX_W-1:0]            grant_idx_o
);

  logic             out_valid_q;
  logic             out_valid_d;
  x_result_t        out_data_q;
  x_result_t        out_data_d;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W-1:0] out_idx_d;

  logic             load_en;
  logic             any_valid;
  logic [IDX_W-1:0] win_idx;
  logic             fire;

  // Register is free when empty or when the core drains it this cycle.
  assign load_en = !out_valid_q | x_result_ready_i;
  assign fire    = load_en & any_valid;

  cv32e40p_xif_rr_arb #(
    .NUM_COPROC (NUM_COPROC),
    .IDX_W      (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (cpr_result_valid_i),
    .en_i      (load_en),
    .gnt_o     (cpr_result_ready_o),
    .gnt_idx_o (win_idx),
    .any_o     (any_valid)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (load_en) begin
      out_valid_d = any_valid;
    end
    if (fire) begin
      out_data_d = cpr_result_i[win_idx];
      out_idx_d  = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign x_result_valid_o = out_valid_q;
  assign x_result_o       = out_data_q;
  assign grant_idx_o      = out_idx_q;

endmodule

// File: tb/tb_cv32e40p_xif_result_arbiter.sv
// Bench for the XIF result arbiter: directed scenarios plus randomized
// traffic checked against a behavioural model of the arbitration rules.
module tb_cv32e40p_xif_result_arbiter;
  import cv32e40p_core_v_xif_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic      [N-1:0]   req_valid = '0;
  logic      [N-1:0]   req_ready;
  x_result_t [N-1:0]   req_data = '0;
  logic                xv;
  logic                xr = 1'b0;
  x_result_t           xo;
  logic      [IW-1:0]  gidx;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit        m_valid;
  x_result_t m_data;
  int        m_idx;
  int        m_ptr;
  logic [N-1:0] hs;

  always #5 clk = ~clk;

  cv32e40p_xif_result_arbiter #(.NUM_COPROC(N)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpr_result_valid_i (req_valid),
    .cpr_result_ready_o (req_ready),
    .cpr_result_i       (req_data),
    .x_result_valid_o   (xv),
    .x_result_ready_i   (xr),
    .x_result_o         (xo),
    .grant_idx_o        (gidx)
  );

  function automatic x_result_t rand_payload();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[$bits(x_result_t)-1:0];
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_idx   = 0;
    m_ptr   = 0;
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w;
    logic [N-1:0] r;
    w = model_pick();
    r = '0;
    if ((!m_valid || xr) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic void model_clock();
    int w;
    w = model_pick();
    if (!m_valid || xr) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = req_data[w];
        m_idx   = w;
        m_ptr   = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  // One clock: capture handshakes, step the model, land 1ns after the edge.
  task automatic advance();
    hs = req_ready & req_valid;
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    req_valid = '0;
    xr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      xr = 1'($urandom_range(1));
      #1;
      n_cmp++;
      if (req_ready !== '0) begin
        n_err++; $display("FAIL reset_ready: got %b want 0", req_ready);
      end
      advance();
      n_cmp++;
      if (xv !== 1'b0 || gidx !== '0 || xo !== '0) begin
        n_err++; $display("FAIL reset_idle: valid %b idx %0d data %h want 0/0/0", xv, gidx, xo);
      end
    end
  endtask

  task automatic test_single();
    x_result_t p;
    p = '0;
    p.id = 4'd3; p.data = 32'hDEADBEEF; p.rd = 5'd5; p.we = 1'b1;
    req_data[1] = p;
    req_valid = 4'b0010;
    xr = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL single_ready: got %b want 0010", req_ready);
    end
    advance();
    req_valid = '0;
    n_cmp++;
    if (xv !== 1'b1 || xo !== p || gidx !== 2'd1) begin
      n_err++; $display("FAIL single_out: valid %b data %h idx %0d want 1 %h 1", xv, xo, gidx, p);
    end
    #1;
    advance();
    n_cmp++;
    if (xv !== 1'b0) begin
      n_err++; $display("FAIL single_empty: valid %b want 0", xv);
    end
  endtask

  task automatic test_contention();
    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
    x_result_t exp_p;
    req_data[0] = rand_payload();
    req_data[1] = rand_payload();
    req_valid = 4'b0011;
    xr = 1'b1;
    foreach (exp_seq[c]) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << exp_seq[c])) begin
        n_err++; $display("FAIL contention_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << exp_seq[c]));
      end
      exp_p = req_data[exp_seq[c]];
      advance();
      n_cmp++;
      if (xv !== 1'b1 || gidx !== IW'(exp_seq[c]) || xo !== exp_p) begin
        n_err++; $display("FAIL contention_out[%0d]: valid %b idx %0d data %h want 1 %0d %h",
                          c, xv, gidx, xo, exp_seq[c], exp_p);
      end
      req_data[exp_seq[c]] = rand_payload();
    end
  endtask

  task automatic test_backpressure();
    x_result_t snap;
    logic [IW-1:0] snap_idx;
    x_result_t exp_p;
    snap = xo;
    snap_idx = gidx;
    xr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== '0) begin
        n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", c, req_ready);
      end
      advance();
      n_cmp++;
      if (xv !== 1'b1 || xo !== snap || gidx !== snap_idx) begin
        n_err++; $display("FAIL stall_hold[%0d]: valid %b idx %0d data %h want 1 %0d %h",
                          c, xv, gidx, xo, snap_idx, snap);
      end
    end
    n_cmp++;
    if (u_dut.u_arb.rr_ptr_q !== 2'd2) begin
      n_err++; $display("FAIL stall_ptr: got %0d want 2", u_dut.u_arb.rr_ptr_q);
    end
    xr = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL release_ready: got %b want 0001", req_ready);
    end
    exp_p = req_data[0];
    advance();
    n_cmp++;
    if (xv !== 1'b1 || gidx !== 2'd0 || xo !== exp_p) begin
      n_err++; $display("FAIL release_out: valid %b idx %0d data %h want 1 0 %h", xv, gidx, xo, exp_p);
    end
    req_valid = '0;
    #1;
    advance();
  endtask

  task automatic test_wrap();
    int exp_seq [3] = '{3, 0, 3};
    x_result_t exp_p;
    req_data[2] = rand_payload();
    req_valid = 4'b0100;
    xr = 1'b1;
    #1;
    advance();
    n_cmp++;
    if (u_dut.u_arb.rr_ptr_q !== 2'd3) begin
      n_err++; $display("FAIL wrap_setup_ptr: got %0d want 3", u_dut.u_arb.rr_ptr_q);
    end
    req_data[0] = rand_payload();
    req_data[3] = rand_payload();
    req_valid = 4'b1001;
    foreach (exp_seq[c]) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << exp_seq[c])) begin
        n_err++; $display("FAIL wrap_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << exp_seq[c]));
      end
      exp_p = req_data[exp_seq[c]];
      advance();
      n_cmp++;
      if (gidx !== IW'(exp_seq[c]) || xo !== exp_p ||
          u_dut.u_arb.rr_ptr_q !== IW'((exp_seq[c] + 1) % N)) begin
        n_err++; $display("FAIL wrap_out[%0d]: idx %0d ptr %0d data %h want %0d %0d %h",
                          c, gidx, u_dut.u_arb.rr_ptr_q, xo, exp_seq[c], (exp_seq[c] + 1) % N, exp_p);
      end
      req_data[exp_seq[c]] = rand_payload();
    end
    req_valid = '0;
    #1;
    advance();
  endtask

  task automatic test_reset_mid_stall();
    req_data[2] = rand_payload();
    req_valid = 4'b0100;
    xr = 1'b0;
    #1;
    advance();
    req_valid = '0;
    #1;
    advance();
    n_cmp++;
    if (xv !== 1'b1 || gidx !== 2'd2) begin
      n_err++; $display("FAIL rst_stall_pre: valid %b idx %0d want 1 2", xv, gidx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (xv !== 1'b0 || xo !== '0 || gidx !== '0) begin
      n_err++; $display("FAIL rst_async: valid %b idx %0d data %h want 0 0 0", xv, gidx, xo);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = rand_payload();
    req_valid = '1;
    xr = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rst_first_ready: got %b want 0001", req_ready);
    end
    advance();
    n_cmp++;
    if (xv !== 1'b1 || gidx !== 2'd0 || xo !== req_data[0]) begin
      n_err++; $display("FAIL rst_first_out: valid %b idx %0d want 1 0", xv, gidx);
    end
    req_valid = '0;
    #1;
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1) == 1) begin
          req_valid[i] = 1'b1;
          req_data[i]  = rand_payload();
        end
      end
      xr = ($urandom_range(9) < 7);
      #1;
      exp_r = model_ready();
      n_cmp++;
      if (req_ready !== exp_r) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_r);
      end
      advance();
      n_cmp++;
      if (xv !== m_valid || (m_valid && (xo !== m_data || gidx !== IW'(m_idx)))) begin
        n_err++; $display("FAIL rand_out[%0d]: valid %b idx %0d data %h want %b %0d %h",
                          c, xv, gidx, xo, m_valid, m_idx, m_data);
      end
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          if ($urandom_range(1) == 1) req_data[i] = rand_payload();
          else req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
